disp_scan_ctrl: RTL
===================

# disp_scan_ctrl

Time-multiplexed refresh controller for the eight-digit seven-segment display. It sits directly upstream of the 8-bit 8-to-1 byte multiplexer and drives its 3-bit select and its eight byte inputs. It also drives the active-low digit anodes and blanks each slot briefly to suppress ghosting. Segment patterns arrive from the CPU/IO side through a valid/ready load port and are double-buffered, so a frame never tears.

## Interface
- TICK_DIV, 50000: clk cycles per digit slot; legal range 2..2^16-1.
- BLANK, 4: cycles at the start of each slot with all anodes off; legal range 1..TICK_DIV-1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable; 0 blanks the display and parks the scanner.
- load_valid  in  1  new pattern word offered.
- load_data  in  64  pattern word; byte k (bits 8k+7:8k) is digit k.
- load_ready  out  1  pending buffer free; a load is accepted when load_valid && load_ready at a clock edge.
- seg_bytes  out  64  active pattern word; byte k feeds multiplexer input Ik.
- s  out  3  multiplexer select = current digit index.
- an  out  8  digit anodes, active-low, at most one bit low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Storage:
  - active register drives seg_bytes.
  - pending register plus pend_full flag.
  - load_ready = !pend_full, registered.
- States:
  - IDLE:
    - an=8'hFF, s=0, counters cleared.
    - If pend_full: active<=pending and pend_full<=0 on the next edge.
    - en=1 -> BLANK, digit 0.
  - BLANK:
    - an=8'hFF, s=digit.
    - Lasts BLANK cycles, then -> SHOW.
  - SHOW:
    - an[digit]=0 and all other an bits =1; s=digit.
    - Lasts TICK_DIV-BLANK cycles.
    - Slot end with digit<7: digit+1 -> BLANK.
    - Slot end with digit==7 is the frame boundary:
      - digit wraps to 0 -> BLANK.
      - frame_done=1 for that one cycle.
      - If pend_full: active<=pending, pend_full<=0.
- en=0 in any state: next cycle IDLE, an=8'hFF, s=0, digit and slot counter cleared. Pending content is kept; it transfers from IDLE as above.
- Accepting a load: pending<=load_data, pend_full<=1, load_ready=0 from the next cycle.
- Load accepted in the same cycle as a transfer: the transfer moves the old pending contents to active first, then the new data occupies pending (pend_full stays 1). Data is never lost or duplicated.
- load_valid while load_ready=0: ignored. The producer holds load_data until it is accepted.
- The digit counter is 3 bits and wraps naturally 7->0. The slot counter is 16 bits and never exceeds TICK_DIV-1.

## Timing
- Reset values:
  - s=0, an=8'hFF, seg_bytes=64'h0, load_ready=1, frame_done=0.
  - State IDLE, pend_full=0.
- All outputs are registered. None is combinationally dependent on inputs.
- en first sampled 1 at edge E:
  - BLANK for digit 0 from E.
  - an[0] goes low at edge E+BLANK and stays low for TICK_DIV-BLANK cycles.
- Slot period is exactly TICK_DIV cycles. Frame period is exactly 8*TICK_DIV cycles.
- frame_done rises with the edge that starts digit 0's BLANK. There is no pulse for the first frame start after leaving IDLE.
- Load-to-display latency:
  - Scanning: new data reaches seg_bytes at the next frame boundary.
  - IDLE: 2 edges after acceptance (accept edge, then transfer edge).
- s changes only on an edge where an is 8'hFF, i.e. BLANK entry. A digit never sees another digit's pattern.
- Asynchronous reset mid-frame forces all reset values immediately. Pending data is discarded.

## Test plan
- Reset: assert rst_n=0 mid-SHOW of digit 5 -> an=8'hFF, s=0, load_ready=1 and seg_bytes=0 without waiting for a clock edge. Release and hold en=0 -> outputs unchanged.
- Scan sequence (TICK_DIV=8, BLANK=2): en=1 -> an cycles FE,FD,FB,F7,EF,DF,BF,7F.
  - Each value lasts 6 cycles, preceded by 2 cycles of FF.
  - s=0..7 aligned with the anodes.
  - frame_done pulses every 64 cycles.
- Idle load: en=0, load 64'h0123456789ABCDEF -> load_ready low 1 cycle. seg_bytes=0123456789ABCDEF 2 edges after acceptance; byte 0 = 8'hEF.
- Tear-free update: while scanning digit 3, load 64'hFFFF0000FFFF0000 -> seg_bytes unchanged until the frame_done edge, then equal to the new word. load_ready stays 0 until then and returns to 1 after.
- Back-pressure plus simultaneous load: pending full, load_valid held with word B -> B not taken until the boundary. At the boundary, A goes to active.
  - B is accepted on the next edge and reaches seg_bytes at the following boundary.
  - Also check acceptance on the exact boundary edge while pend_full=0: that word reaches seg_bytes at the following boundary.
- Disable mid-frame: en=0 during SHOW of digit 6 -> next cycle an=8'hFF, s=0. Re-enable -> scan restarts at digit 0 with BLANK, and no frame_done for that restart.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl -- refresh controller for an eight-digit seven-segment display.
//
// Scans digits 0..7. Each digit owns a slot of TICK_DIV cycles. The first BLANK
// cycles of a slot hold all anodes off so the segment lines can settle before
// the next digit lights. Pattern words come in through a valid/ready port.
// They are staged in a pending buffer and move to the active buffer only at a
// frame boundary (or straight away while idle), so a frame never shows a mix
// of old and new data.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable; low parks the scanner in IDLE with anodes off
//   load_valid  producer offers load_data
//   load_data   64-bit pattern word, byte k = digit k
//   load_ready  pending buffer is free (registered)
//   seg_bytes   active pattern word, byte k feeds mux input Ik
//   s           mux select = current digit index
//   an          active-low digit anodes, at most one bit low
//   frame_done  one-cycle pulse at every frame boundary while scanning
module disp_scan_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int BLANK    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_valid,
  input  logic [63:0] load_data,
  output logic        load_ready,
  output logic [63:0] seg_bytes,
  output logic [2:0]  s,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam logic [15:0] SLOT_LAST  = 16'(TICK_DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

  state_t      state_q;
  logic [2:0]  digit_q;
  logic [15:0] slot_q;
  logic [63:0] active_q;
  logic [63:0] pend_q;
  logic        pend_full_q;
  logic        pend_full_d;
  logic        load_ready_q;
  logic [7:0]  an_q;
  logic [2:0]  s_q;
  logic        frame_done_q;

  logic        accept;
  logic        slot_end;
  logic        boundary;
  logic        transfer;
  logic [7:0]  show_an;

  // Anode pattern for the SHOW phase of the current digit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_an
      assign show_an[gi] = (digit_q != 3'(gi));
    end
  endgenerate

  assign accept   = load_valid && load_ready_q;
  assign slot_end = (slot_q == SLOT_LAST);
  // A frame boundary only counts while scanning continues; a disable on the
  // same edge takes priority and the transfer then happens from IDLE.
  assign boundary = en && (state_q == ST_SHOW) && slot_end && (digit_q == 3'd7);
  assign transfer = pend_full_q && (boundary || (state_q == ST_IDLE));

  // Transfer empties pending first; a load on the same edge refills it.
  always_comb begin
    pend_full_d = pend_full_q;
    if (transfer) pend_full_d = 1'b0;
    if (accept)   pend_full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      digit_q      <= 3'd0;
      slot_q       <= 16'd0;
      active_q     <= 64'h0;
      pend_q       <= 64'h0;
      pend_full_q  <= 1'b0;
      load_ready_q <= 1'b1;
      an_q         <= 8'hFF;
      s_q          <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      if (transfer) active_q <= pend_q;
      if (accept)   pend_q   <= load_data;
      pend_full_q  <= pend_full_d;
      load_ready_q <= !pend_full_d;
      frame_done_q <= 1'b0;

      if (!en) begin
        state_q <= ST_IDLE;
        digit_q <= 3'd0;
        slot_q  <= 16'd0;
        an_q    <= 8'hFF;
        s_q     <= 3'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Leaving IDLE starts digit 0 without a frame_done pulse.
            state_q <= ST_BLANK;
            digit_q <= 3'd0;
            slot_q  <= 16'd0;
            an_q    <= 8'hFF;
            s_q     <= 3'd0;
          end
          ST_BLANK: begin
            slot_q <= slot_q + 16'd1;
            if (slot_q == BLANK_LAST) begin
              state_q <= ST_SHOW;
              an_q    <= show_an;
            end
          end
          ST_SHOW: begin
            if (slot_end) begin
              // Select changes only here, while the anodes go dark.
              state_q      <= ST_BLANK;
              slot_q       <= 16'd0;
              digit_q      <= digit_q + 3'd1;
              s_q          <= digit_q + 3'd1;
              an_q         <= 8'hFF;
              frame_done_q <= (digit_q == 3'd7);
            end else begin
              slot_q <= slot_q + 16'd1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            digit_q <= 3'd0;
            slot_q  <= 16'd0;
            an_q    <= 8'hFF;
            s_q     <= 3'd0;
          end
        endcase
      end
    end
  end

  assign load_ready = load_ready_q;
  assign seg_bytes  = active_q;
  assign s          = s_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
